baudgen_frac: RTL and testbench

Parametrised fractional baud-tick generator: a runtime-programmable successor to the fixed-rate TX baud generator. It emits one-cycle bit ticks at an average period of `div_int + div_frac/2^FRAC_W` system clocks. Its TX mode ticks at the start of each bit; its RX mode places the first tick mid-bit for centre sampling. It sits between the UART control logic (`ena`, divisor registers) and the uart_tx/uart_rx shift engines.

---
 rtl/baudgen_frac.sv | 134 +++++++++++++
 tb/tb_baudgen_frac.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/baudgen_frac.sv
// ---------------------------------------------------------------------------
// baudgen_frac
//
// Fractional baud-tick generator. Emits single-cycle ticks at an average
// period of div_int + div_frac/2^FRAC_W system clocks. TX mode ticks at the
// start of each bit. RX mode delays the first tick by half a bit so that the
// shift engine samples at bit centre.
//
// Optional feature macro: BAUDGEN_FRAC_EN
//   defined   : fractional phase accumulator present, div_frac honoured.
//   undefined : accumulator removed, div_frac ignored, every period is a_int.
//   The port list is identical in both builds.
//
// Parameters
//   DIV_W       : width of the integer divisor and of the period counter
//   FRAC_W      : width of the fractional divisor and of the accumulator
//   DEFAULT_DIV : active integer divisor after reset
//
// Ports
//   clk      in  : system clock, rising edge
//   rst      in  : asynchronous reset, active-high
//   ena      in  : 1 = generate ticks, 0 = stopped and re-armed
//   mode     in  : 0 = TX (tick on first enabled cycle), 1 = RX (mid-bit)
//   div_int  in  : requested cycles per bit, integer part
//   div_frac in  : requested fractional part, units of 2^-FRAC_W
//   div_load in  : single-cycle strobe, latches the divisor while running
//   tick     out : bit tick, one cycle wide
//   div_err  out : registered, 1 while the active divisor is clamped to 2
// ---------------------------------------------------------------------------
module baudgen_frac #(
    parameter int DIV_W       = 16,
    parameter int FRAC_W      = 4,
    parameter int DEFAULT_DIV = 104
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              mode,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              tick,
    output logic              div_err
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] a_int;

    logic             load_now;
    logic             clamp;
    logic [DIV_W-1:0] ld_int;
    logic [DIV_W-1:0] eff_int;
    logic [DIV_W-1:0] rx_start;
    logic [DIV_W-1:0] reload_val;
    logic             carry;

    // The divisor follows the inputs every cycle while stopped; while running
    // it only changes on the strobe.
    assign load_now = !ena || div_load;

    // A divisor below 2 cannot produce distinct ticks; it is stored as 2.
    assign clamp  = (div_int < DIV_W'(2));
    assign ld_int = clamp ? DIV_W'(2) : div_int;

    // Divisor seen by a reload this cycle: a coincident strobe wins.
    assign eff_int = load_now ? ld_int : a_int;

    // RX preload puts the first tick half a bit after enable. ld_int >= 2,
    // so this never underflows.
    assign rx_start = (ld_int >> 1) - DIV_W'(1);

    // a_int >= 2 guarantees a_int - 1 + carry fits in DIV_W bits.
    assign reload_val = eff_int - DIV_W'(1) + {{(DIV_W-1){1'b0}}, carry};

`ifdef BAUDGEN_FRAC_EN
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] a_frac;
    logic [FRAC_W-1:0] eff_frac;
    logic [FRAC_W-1:0] acc_next;

    assign eff_frac          = load_now ? div_frac : a_frac;
    // The accumulator overflow stretches the current period by one cycle.
    assign {carry, acc_next} = {1'b0, acc} + {1'b0, eff_frac};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            a_frac <= '0;
        end else begin
            if (load_now) begin
                a_frac <= div_frac;
            end
            if (!ena) begin
                acc <= '0;
            end else if (cnt == '0) begin
                acc <= acc_next;
            end
        end
    end
`else
    // Integer-only build: no carry, so every period is exactly a_int.
    logic frac_unused;
    assign frac_unused = ^div_frac;
    assign carry       = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            a_int   <= DIV_W'(DEFAULT_DIV);
            div_err <= 1'b0;
        end else begin
            if (load_now) begin
                a_int   <= ld_int;
                div_err <= clamp;
            end
            if (!ena) begin
                // mode only matters here, so changing it while running is
                // ignored until the next stop.
                cnt <= mode ? rx_start : '0;
            end else if (cnt == '0) begin
                cnt <= reload_val;
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

    // rst gating keeps tick low during reset even though cnt reads 0.
    assign tick = ena && !rst && (cnt == '0);

endmodule

// File: tb/tb_baudgen_frac.sv
// ---------------------------------------------------------------------------
// tb_baudgen_frac
//
// Directed bench for baudgen_frac. A cycle is taken as negedge-to-negedge:
// inputs change just after a negedge and tick is sampled 1 ns later, well
// before the rising edge that acts on those inputs.
// ---------------------------------------------------------------------------
module tb_baudgen_frac;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;

`ifdef BAUDGEN_FRAC_EN
    localparam int FRAC_SPAN = 1667;
    localparam int LONG_P    = 105;
`else
    localparam int FRAC_SPAN = 1664;
    localparam int LONG_P    = 104;
`endif

    logic              clk;
    logic              rst;
    logic              ena;
    logic              mode;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              tick;
    logic              div_err;

    int n_cmp = 0;
    int n_err = 0;
    int tpos[$];

    baudgen_frac #(
        .DIV_W      (DIV_W),
        .FRAC_W     (FRAC_W),
        .DEFAULT_DIV(104)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .mode    (mode),
        .div_int (div_int),
        .div_frac(div_frac),
        .div_load(div_load),
        .tick    (tick),
        .div_err (div_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Tick position k of the last recording, or -1 if absent.
    function automatic int tp(input int k);
        return (k < tpos.size()) ? tpos[k] : -1;
    endfunction

    // Period k (1-based) of the last recording, or -1 if absent.
    function automatic int per(input int k);
        return (tp(k) < 0 || tp(k-1) < 0) ? -1 : tp(k) - tp(k-1);
    endfunction

    // Records tick positions over ncyc cycles; optional single strobes.
    task automatic record(input int ncyc, input int ld_a, input int val_a,
                          input int ld_b, input int val_b);
        tpos.delete();
        for (int i = 0; i < ncyc; i++) begin
            div_load = (i == ld_a) || (i == ld_b);
            if (i == ld_a)      div_int = DIV_W'(val_a);
            else if (i == ld_b) div_int = DIV_W'(val_b);
            else if (ld_a >= 0) div_int = DIV_W'(77);
            #1;
            if (tick) tpos.push_back(i);
            @(negedge clk);
        end
        div_load = 1'b0;
    endtask

    // Stop for one cycle so the divisor and preload are taken from the inputs.
    task automatic stop_and_arm(input logic m, input int di, input int df);
        ena      = 1'b0;
        mode     = m;
        div_int  = DIV_W'(di);
        div_frac = FRAC_W'(df);
        #1;
        check("stopped_tick", int'(tick), 0);
        @(negedge clk);
        ena = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        ena      = 1'b1;
        mode     = 1'b0;
        div_int  = DIV_W'(104);
        div_frac = '0;
        div_load = 1'b0;

        // Reset state: tick held low even with ena high.
        @(negedge clk);
        #1;
        check("reset_tick", int'(tick), 0);
        check("reset_div_err", int'(div_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // TX at 104: ticks at 0 and every 104 cycles, 10 periods.
        stop_and_arm(1'b0, 104, 0);
        record(1042, -1, 0, -1, 0);
        check("tx_count", tpos.size(), 11);
        check("tx_first", tp(0), 0);
        for (int k = 1; k <= 10; k++) check($sformatf("tx_period%0d", k), per(k), 104);

        // RX at 104: first tick mid-bit, then full periods.
        stop_and_arm(1'b1, 104, 0);
        record(260, -1, 0, -1, 0);
        check("rx_count", tpos.size(), 3);
        check("rx_first", tp(0), 51);
        check("rx_second", tp(1), 155);
        check("rx_third", tp(2), 259);

        // Fractional 104 + 3/16: 16 periods.
        stop_and_arm(1'b0, 104, 3);
        record(1670, -1, 0, -1, 0);
        check("frac_span16", tp(16), FRAC_SPAN);
        check("frac_period5", per(5), 104);
        check("frac_period6", per(6), LONG_P);
        check("frac_period11", per(11), LONG_P);
        check("frac_period16", per(16), LONG_P);

        // Strobe 52 mid-period, then 104 coincident with a reload.
        stop_and_arm(1'b0, 104, 0);
        record(330, 50, 52, 208, 104);
        check("load_count", tpos.size(), 5);
        check("load_cur_period", tp(1), 104);
        check("load_new_period", per(2), 52);
        check("load_new_period2", per(3), 52);
        check("load_coincident", tp(4), 312);

        // Clamp: div_int=1 stored as 2 with div_err one cycle later.
        stop_and_arm(1'b0, 1, 0);
        ena = 1'b0;
        @(negedge clk);
        #1;
        check("clamp_err_set", int'(div_err), 1);
        ena = 1'b1;
        record(9, -1, 0, -1, 0);
        check("clamp_count", tpos.size(), 5);
        check("clamp_last", tp(4), 8);

        stop_and_arm(1'b0, 10, 0);
        #1;
        check("clamp_err_clear", int'(div_err), 0);
        record(21, -1, 0, -1, 0);
        check("div10_count", tpos.size(), 3);
        check("div10_last", tp(2), 20);

        // Reset mid-period: default divisor restored, fresh phase on release.
        stop_and_arm(1'b0, 104, 0);
        record(30, -1, 0, -1, 0);
        div_int = DIV_W'(50);
        rst     = 1'b1;
        #1;
        check("midrst_tick", int'(tick), 0);
        @(negedge clk);
        rst = 1'b0;
        record(210, -1, 0, -1, 0);
        check("rst_count", tpos.size(), 3);
        check("rst_first", tp(0), 0);
        check("rst_period", per(1), 104);
        check("rst_period2", per(2), 104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
